pattern_scan_sched: RTL

Time-shared serial pattern scanner. NCH serial-bit channels compete for one shared match engine. The block arbitrates the channels round-robin, keeps a per-channel bit-history context, and reports matches against a programmable PLEN-bit pattern. It also counts hits per channel. It sits between the serial front-ends and status/readout logic, replacing one detector FSM per channel.

---
 rtl/pattern_scan_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_sched.sv
// pattern_scan_sched
//   Time-shared serial pattern scanner. NCH serial channels share one match
//   engine. Each cycle at most one eligible channel (req & ch_en) is granted.
//   Its bit is shifted into that channel's private history, and a match
//   against the programmable PLEN-bit pattern is reported one cycle later.
//   Per-channel saturating hit counters can be read back through rd_sel/rd_cnt.
//
//   Build option: define STRICT_PRIO_EN to select fixed priority, where the
//   lowest index wins and there is no rotating pointer. The default build is
//   round-robin.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   req          per-channel bit-available request
//   bit_in       per-channel serial bit, valid with req
//   ch_en        channel enable mask; disabled channels are never granted
//   cfg_we       loads cfg_pattern, clears contexts/counters, blocks grants
//   cfg_pattern  match pattern, MSB = oldest bit
//   gnt          one-hot combinational grant; bit consumed at the clock edge
//   det_valid    registered one-cycle match pulse
//   det_ch       channel of the match, valid with det_valid
//   rd_sel       counter readout select
//   rd_cnt       registered hit count of channel rd_sel
module pattern_scan_sched #(
  parameter int NCH   = 4,
  parameter int PLEN  = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   bit_in,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_we,
  input  logic [PLEN-1:0]  cfg_pattern,
  output logic [NCH-1:0]   gnt,
  output logic             det_valid,
  output logic [CH_W-1:0]  det_ch,
  input  logic [CH_W-1:0]  rd_sel,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam int FILL_W = $clog2(PLEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PLEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PLEN-1:0]   pattern_q, pattern_d;
  logic [PLEN-1:0]   hist_q [NCH];
  logic [PLEN-1:0]   hist_d [NCH];
  logic [FILL_W-1:0] fill_q [NCH];
  logic [FILL_W-1:0] fill_d [NCH];
  logic [CNT_W-1:0]  cnt_q  [NCH];
  logic [CNT_W-1:0]  cnt_d  [NCH];
  logic              det_valid_q, det_valid_d;
  logic [CH_W-1:0]   det_ch_q, det_ch_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  logic [NCH-1:0]    elig;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_sel;
  logic [PLEN-1:0]   hist_new;
  logic [FILL_W-1:0] fill_new;
  logic              match;

`ifndef STRICT_PRIO_EN
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W:0]     rr_cand;
`endif

  assign elig = req & ch_en;

  // Grant selection. cfg_we and reset both suppress the grant so that a
  // requester holds its bit and retries on a later cycle.
`ifdef STRICT_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt_sel = CH_W'(i);
      end
    end
    if (reset || cfg_we) gnt_any = 1'b0;
  end
`else
  // Search rr_ptr, rr_ptr+1, ... modulo NCH. The modulo is done with an
  // explicit compare so that a non-power-of-two NCH also works.
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = '0;
    rr_cand = '0;
    for (int i = 0; i < NCH; i++) begin
      rr_cand = {1'b0, rr_ptr_q} + (CH_W + 1)'(i);
      if (rr_cand >= (CH_W + 1)'(NCH)) rr_cand = rr_cand - (CH_W + 1)'(NCH);
      if (!gnt_any && elig[rr_cand[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_sel = rr_cand[CH_W-1:0];
      end
    end
    if (reset || cfg_we) gnt_any = 1'b0;
  end
`endif

  assign gnt = gnt_any ? (NCH'(1) << gnt_sel) : '0;

  // Updated context of the granted channel. The match uses the new values,
  // so the bit accepted this cycle takes part in the comparison.
  assign hist_new = {hist_q[gnt_sel][PLEN-2:0], bit_in[gnt_sel]};
  assign fill_new = (fill_q[gnt_sel] == FILL_MAX) ? FILL_MAX : fill_q[gnt_sel] + 1'b1;
  assign match    = gnt_any && (hist_new == pattern_q) && (fill_new == FILL_MAX);

  always_comb begin
    pattern_d   = pattern_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    det_valid_d = 1'b0;
    det_ch_d    = det_ch_q;
    // Readout samples the counter before any increment at the same edge.
    rd_cnt_d    = cnt_q[rd_sel];
`ifndef STRICT_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      for (int k = 0; k < NCH; k++) begin
        hist_d[k] = '0;
        fill_d[k] = '0;
        cnt_d[k]  = '0;
      end
`ifndef STRICT_PRIO_EN
      rr_ptr_d = '0;
`endif
    end else if (gnt_any) begin
      hist_d[gnt_sel] = hist_new;
      fill_d[gnt_sel] = fill_new;
`ifndef STRICT_PRIO_EN
      rr_ptr_d = (gnt_sel == CH_W'(NCH - 1)) ? '0 : gnt_sel + 1'b1;
`endif
      // History is kept after a match, so overlapping occurrences are found.
      if (match) begin
        det_valid_d = 1'b1;
        det_ch_d    = gnt_sel;
        if (cnt_q[gnt_sel] != CNT_MAX) cnt_d[gnt_sel] = cnt_q[gnt_sel] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q   <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      rd_cnt_q    <= '0;
`ifndef STRICT_PRIO_EN
      rr_ptr_q    <= '0;
`endif
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= '0;
        fill_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      pattern_q   <= pattern_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      rd_cnt_q    <= rd_cnt_d;
`ifndef STRICT_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
      for (int k = 0; k < NCH; k++) begin
        hist_q[k] <= hist_d[k];
        fill_q[k] <= fill_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign rd_cnt    = rd_cnt_q;

endmodule
